alu_control: RTL and testbench

ALU_CONTROL -- requirements
Module: alu_control

---
 rtl/alu_control.sv | 68 ++++++
 tb/tb_alu_control.sv | 94 +++++++++
 2 files changed

// File: rtl/alu_control.sv
// alu_control: registered ALU operation decode from ALUOp/funct with stall and sync reset.
// Define ALU_CTRL_EXT_OPS_EN to decode the extended R-type ops (XOR/SLL/SRL/SRA/SLT/SLTU).
module alu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] ALUOp,
  input  logic [3:0] funct,
  output logic [3:0] ALUCtrl,
  output logic       illegal
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_INV  = 4'b1111;
`ifdef ALU_CTRL_EXT_OPS_EN
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
`endif
  logic [3:0] r_type;
  logic [3:0] ctrl_d, ctrl_q;
  logic       illegal_d, illegal_q;
  always_comb begin
    r_type = OP_INV;
    case (funct)
      4'b0000: r_type = OP_ADD;
      4'b1000: r_type = OP_SUB;
      4'b0111: r_type = OP_AND;
      4'b0110: r_type = OP_OR;
`ifdef ALU_CTRL_EXT_OPS_EN
      4'b0100: r_type = OP_XOR;
      4'b0001: r_type = OP_SLL;
      4'b0101: r_type = OP_SRL;
      4'b1101: r_type = OP_SRA;
      4'b0010: r_type = OP_SLT;
      4'b0011: r_type = OP_SLTU;
`endif
      default: r_type = OP_INV;
    endcase
  end
  // The parity selector only misses both items when an input bit is X/Z, forcing INVALID.
  always_comb begin
    ctrl_d = OP_INV;
    case (^{ALUOp, funct})
      1'b0, 1'b1: ctrl_d = (ALUOp == 2'b00) ? OP_ADD :
                           (ALUOp == 2'b01) ? OP_SUB :
                           (ALUOp == 2'b10) ? r_type : OP_INV;
      default:    ctrl_d = OP_INV;
    endcase
    illegal_d = (ctrl_d == OP_INV);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= OP_ADD;
      illegal_q <= 1'b0;
    end else if (en) begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end
  assign ALUCtrl = ctrl_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: directed and random checks of alu_control against a table-driven model.
module tb_alu_control;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] ALUOp;
  logic [3:0] funct;
  logic [3:0] ALUCtrl;
  logic       illegal;
  logic [3:0] r_tab [16];
  logic [3:0] exp_ctrl;
  logic       exp_ill;
  int         n_vec = 0;
  int         n_err = 0;

  alu_control dut (
    .clk(clk), .rst(rst), .en(en), .ALUOp(ALUOp), .funct(funct),
    .ALUCtrl(ALUCtrl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got ctrl=%b ill=%b, want ctrl=%b ill=%b",
               tag, obs[4:1], obs[0], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [3:0] model_dec(input logic [1:0] op, input logic [3:0] f);
    case (op)
      2'b00:   return 4'b0010;
      2'b01:   return 4'b0110;
      2'b10:   return r_tab[f];
      default: return 4'b1111;
    endcase
  endfunction

  task automatic apply(input string tag, input logic r, input logic e,
                       input logic [1:0] op, input logic [3:0] f);
    @(negedge clk);
    rst = r; en = e; ALUOp = op; funct = f;
    @(posedge clk);
    if (r) begin
      exp_ctrl = 4'b0010;
      exp_ill  = 1'b0;
    end else if (e) begin
      exp_ctrl = model_dec(op, f);
      exp_ill  = (exp_ctrl == 4'b1111);
    end
    #1 check(tag, {ALUCtrl, illegal}, {exp_ctrl, exp_ill});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) r_tab[i] = 4'b1111;
    r_tab[4'b0000] = 4'b0010;
    r_tab[4'b1000] = 4'b0110;
    r_tab[4'b0111] = 4'b0000;
    r_tab[4'b0110] = 4'b0001;
`ifdef ALU_CTRL_EXT_OPS_EN
    r_tab[4'b0100] = 4'b0011;
    r_tab[4'b0001] = 4'b0100;
    r_tab[4'b0101] = 4'b0101;
    r_tab[4'b1101] = 4'b0111;
    r_tab[4'b0010] = 4'b1000;
    r_tab[4'b0011] = 4'b1001;
`endif
    rst = 1'b1; en = 1'b0; ALUOp = 2'b11; funct = 4'b1111;
    exp_ctrl = 4'b0010; exp_ill = 1'b0;
    apply("reset", 1, 1, 2'b11, 4'b1111);
    apply("ld_st_add", 0, 1, 2'b00, 4'b0000);
    apply("branch_sub", 0, 1, 2'b01, 4'b0000);
    apply("r_add", 0, 1, 2'b10, 4'b0000);
    apply("r_and", 0, 1, 2'b10, 4'b0111);
    apply("r_or", 0, 1, 2'b10, 4'b0110);
    apply("aluop11_inv", 0, 1, 2'b11, 4'b1111);
    apply("r_inv", 0, 1, 2'b10, 4'b1111);
    apply("r_xor_cfg", 0, 1, 2'b10, 4'b0100);
    apply("r_sra_cfg", 0, 1, 2'b10, 4'b1101);
    apply("ld_st_any_funct", 0, 1, 2'b00, 4'b1010);
    apply("r_sub", 0, 1, 2'b10, 4'b1000);
    apply("stall_hold", 0, 0, 2'b00, 4'b0000);
    apply("stall_hold2", 0, 0, 2'b11, 4'b1111);
    apply("rst_over_stall", 1, 0, 2'b11, 4'b1111);
    apply("rst_over_en", 1, 1, 2'b11, 4'b1111);
    apply("post_rst_first", 0, 1, 2'b01, 4'b0101);
    for (int i = 0; i < 400; i++)
      apply("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom), 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
